// File: rtl/arb4_mux_ctrl.sv
// Four-way round-robin arbiter that owns the select line of a shared mux4; grants persist until release.
// Optional forced release after TIMEOUT_CYCLES owned cycles is compiled in with `define ARB_TIMEOUT_EN.
module arb4_mux_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] grant_n;
    logic [1:0] select_n;
    logic       busy_n;
    logic       timeout_n;
    logic       to_hit;
    logic [2:0] win;

    // Returns {found, index}: first set bit searching base, base+1, base+2, base+3 (mod 4).
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) pick = {1'b1, idx};
        end
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt, cnt_n;

    assign to_hit = (state == OWNED) && (cnt == CNT_LAST);
`else
    // Without the feature the grant is held indefinitely; the term is constant false.
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        grant_n   = grant;
        select_n  = select;
        busy_n    = busy;
        timeout_n = 1'b0;
        win       = 3'b000;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt;
`endif
        case (state)
            IDLE: begin
                win = pick(req, ptr);
                if (win[2]) begin
                    state_n  = OWNED;
                    grant_n  = 4'b0001 << win[1:0];
                    select_n = win[1:0];
                    busy_n   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_n    = '0;
`endif
                end
            end
            OWNED: begin
                if (done || !req[select] || to_hit) begin
                    // The released owner drops to lowest priority; re-arbitrate on the same edge.
                    ptr_n     = select + 2'd1;
                    timeout_n = to_hit && !done && req[select];
                    win       = pick(req, select + 2'd1);
                    if (win[2]) begin
                        grant_n  = 4'b0001 << win[1:0];
                        select_n = win[1:0];
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                        busy_n  = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            grant   <= 4'b0000;
            select  <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            grant   <= grant_n;
            select  <= select_n;
            busy    <= busy_n;
            timeout <= timeout_n;
`ifdef ARB_TIMEOUT_EN
            cnt     <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_arb4_mux_ctrl.sv
// Directed bench for arb4_mux_ctrl; the timeout scenario follows whether ARB_TIMEOUT_EN is defined.
module tb_arb4_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    arb4_mux_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .select  (select),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
        check({tag, ".grant"},   8'(grant),   8'(g));
        check({tag, ".select"},  8'(select),  8'(s));
        check({tag, ".busy"},    8'(busy),    8'(b));
        check({tag, ".timeout"}, 8'(timeout), 8'(t));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester, then release via done.
        req = 4'b0100;
        tick();
        expect_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000; done = 1'b1;
        tick();
        expect_out("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b1;
        tick();
        expect_out("done_in_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        expect_out("idle_hold", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Full rotation with done every owned cycle: no idle bubble.
        do_reset();
        req = 4'b1111;
        tick();
        expect_out("rr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("rr1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        expect_out("rr2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out("rr3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        expect_out("rr4", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b0; req = 4'b0000;
        tick();
        expect_out("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 1, no preemption, release by req drop; ptr=2 makes 3 beat 0.
        do_reset();
        req = 4'b0010;
        tick();
        expect_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1010;
        tick();
        expect_out("no_preempt", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1001;
        tick();
        expect_out("drop_release", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("drop_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Reset mid-grant, then arbitration restarts from requester 0.
        do_reset();
        req = 4'b0010;
        tick();
        expect_out("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        expect_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b1010;
        tick();
        expect_out("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Hold with two requesters and no done.
        do_reset();
        req = 4'b0011;
        tick();
        expect_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_out($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        expect_out("to_fire", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        expect_out("to_after", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("to_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("to_with_done", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b0;
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            expect_out($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb4_mux_ctrl.md
ARB4_MUX_CTRL -- requirements
Module: arb4_mux_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum grant hold in cycles when the timeout feature is compiled in.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, one request per requester; bit i belongs to requester i.
REQ-005 The block SHALL have port done, input, 1, a one-cycle release pulse from the current owner.
REQ-006 The block SHALL have port grant, output, 4, one-hot registered grant; all zeros when idle.
REQ-007 The block SHALL have port select, output, 2, the index of the current owner, driven to the select input of the shared mux4.
REQ-008 The block SHALL have port busy, output, 1, high while any grant is active.
REQ-009 The block SHALL have port timeout, output, 1, a one-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement two states: IDLE (grant 0, busy 0) and OWNED (exactly one grant bit set, busy 1).
REQ-011 In IDLE with req != 0, the block SHALL enter OWNED on the next edge, granting the first set req bit searched ptr, ptr+1, ptr+2, ptr+3 mod 4; latency is 1 cycle from req to grant.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with grant, busy and ptr unchanged.
REQ-013 While OWNED, select SHALL equal the owner index, grant SHALL equal 1 << owner, and both SHALL be stable until release.
REQ-014 A release SHALL occur on the edge where done == 1, or where req[owner] == 0, whichever comes first.
REQ-015 At a release edge, ptr SHALL become (owner + 1) mod 4, so the released owner has lowest priority.
REQ-016 At a release edge with any req bit set (the owner's own bit included), the block SHALL re-arbitrate in the same edge using the updated ptr and grant the winner with no idle bubble.
REQ-017 At a release edge with req == 0, the block SHALL return to IDLE.
REQ-018 Pulses of done while IDLE SHALL be ignored.
REQ-019 New requests from non-owners while OWNED SHALL be ignored until release; there is no preemption.
REQ-020 In IDLE, select SHALL hold its last value, so the mux output stays defined.
REQ-021 In every state, timeout SHALL be 0 except as stated in REQ-026.

Reset
REQ-022 On a rising clk edge with rst == 1, the block SHALL set state = IDLE, grant = 4'b0000, select = 2'b00, busy = 0, timeout = 0, ptr = 0, and hold count = 0.
REQ-023 rst SHALL override every other input, including reset asserted mid-grant; the next arbitration after reset starts from requester 0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL select whether the timeout feature is compiled in.
REQ-025 With ARB_TIMEOUT_EN defined, a hold counter SHALL clear on each new grant and increment every OWNED cycle.
REQ-026 With ARB_TIMEOUT_EN defined, once the owner has held for TIMEOUT_CYCLES cycles, the block SHALL force a release per REQ-015 to REQ-017 on that edge and pulse timeout for 1 cycle.
REQ-027 With ARB_TIMEOUT_EN defined, a done on the same edge as the timeout SHALL count as a normal release, with timeout = 0.
REQ-028 With ARB_TIMEOUT_EN undefined, no counter SHALL exist, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely.

Verification
REQ-029 Reset then req = 4'b0100 -> one cycle later grant = 4'b0100, select = 2'b10, busy = 1; after done, grant = 0 and busy = 0.
REQ-030 req = 4'b1111 from reset, with done pulsed each owned cycle -> grants in order 0001, 0010, 0100, 1000, 0001, with no idle cycle between them.
REQ-031 Owner 1 holds, req[3] rises, then req[1] drops -> next edge grant = 4'b1000, select = 2'b11, ptr = 2 after the release.
REQ-032 rst asserted while grant = 4'b0010 -> next edge grant = 0, select = 0, busy = 0; then req = 4'b1010 -> grant = 4'b0010.
REQ-033 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, req = 4'b0011 held, done never pulsed -> owner 0 held 4 cycles, timeout pulses, grant = 4'b0010 next.
REQ-034 ARB_TIMEOUT_EN undefined, same stimulus as REQ-033 -> grant stays 4'b0001 for 100 cycles and timeout stays 0.
